// File: rtl/cu_state_sequencer.sv
// State register and next-state logic of the multicycle RISC-V control unit.
// Optional retired-instruction counter is enabled with the CU_INSTR_COUNT_EN macro.
module cu_state_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             Opcode,
    input  logic                   MemReady,
    output logic [3:0]             StateRegister,
    output logic                   IllegalOp,
    output logic                   MemTimeout,
`ifdef CU_INSTR_COUNT_EN
    output logic [COUNT_WIDTH-1:0] InstrCount,
`endif
    output logic                   InstrRetired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_RCOMPLETE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_OP      = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    function automatic op_class_t decode_class(input logic [6:0] op);
        case (op)
            7'b0000011: decode_class = CLS_LOAD;
            7'b0100011: decode_class = CLS_STORE;
            7'b0110011: decode_class = CLS_OP;
            7'b1100011: decode_class = CLS_BRANCH;
            7'b1101111: decode_class = CLS_JAL;
            default:    decode_class = CLS_ILLEGAL;
        endcase
    endfunction

    state_t            state_q, state_d;
    op_class_t         class_q, class_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              retired_q, retired_d;
    logic              wait_zone;
    logic              timeout_hit;

    assign wait_zone   = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                         (state_q == S_MEMWRITE);
    // MemReady takes priority over the threshold: the abort only fires while still waiting.
    assign timeout_hit = (MEM_TIMEOUT != 0) && wait_zone && !MemReady &&
                         (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        wait_d    = wait_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        retired_d = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                class_d = decode_class(Opcode);
                case (decode_class(Opcode))
                    CLS_LOAD, CLS_STORE: state_d = S_MEMADDR;
                    CLS_OP:              state_d = S_EXEC_R;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JAL:             state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                if (class_q == CLS_LOAD) begin
                    state_d = S_MEMREAD;
                end else if (class_q == CLS_STORE) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWB: begin
                state_d   = S_FETCH;
                retired_d = 1'b1;
            end
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d   = S_FETCH;
                    retired_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end
            end
            S_EXEC_R:    state_d = S_RCOMPLETE;
            S_RCOMPLETE, S_BRANCH, S_JUMP: begin
                state_d   = S_FETCH;
                retired_d = 1'b1;
            end
            default:     state_d = S_FETCH;
        endcase

        // A fetch timeout stays in FETCH, so it must clear the counter explicitly.
        if ((state_d != state_q) || MemReady || timeout_d || !wait_zone) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            class_q   <= CLS_NONE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    assign StateRegister = state_q;
    assign IllegalOp     = illegal_q;
    assign MemTimeout    = timeout_q;
    assign InstrRetired  = retired_q;

`ifdef CU_INSTR_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (retired_q) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign InstrCount = count_q;
`endif

endmodule

// File: tb/tb_cu_state_sequencer.sv
// Directed bench for cu_state_sequencer: vector table plus hand sequences for
// reset, memory waits, timeouts and counter wrap (counter checks need CU_INSTR_COUNT_EN).
module tb_cu_state_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;
    localparam logic [6:0] OP_X     = 7'b0000000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic [3:0]    state;
    logic          illegal_op;
    logic          mem_timeout;
    logic          instr_retired;
`ifdef CU_INSTR_COUNT_EN
    logic [CW-1:0] instr_count;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_count = '0;

    typedef struct {
        logic [6:0] op;
        logic       mr;
        logic [3:0] st;
        logic       ill;
        logic       to;
        logic       ret;
    } vec_t;

    vec_t vecs[24];

    cu_state_sequencer #(
        .MEM_TIMEOUT(TO),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Opcode       (opcode),
        .MemReady     (mem_ready),
        .StateRegister(state),
        .IllegalOp    (illegal_op),
        .MemTimeout   (mem_timeout),
`ifdef CU_INSTR_COUNT_EN
        .InstrCount   (instr_count),
`endif
        .InstrRetired (instr_retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares all outputs; the counter model advances one cycle after a retire pulse.
    task automatic check_out(input string name, input logic [3:0] es,
                             input logic ei, input logic eto, input logic er);
        n_tests++;
        if (state !== es) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", name, state, es);
        end
        n_tests++;
        if (illegal_op !== ei) begin
            n_fail++;
            $display("FAIL %s IllegalOp: got %b expected %b", name, illegal_op, ei);
        end
        n_tests++;
        if (mem_timeout !== eto) begin
            n_fail++;
            $display("FAIL %s MemTimeout: got %b expected %b", name, mem_timeout, eto);
        end
        n_tests++;
        if (instr_retired !== er) begin
            n_fail++;
            $display("FAIL %s InstrRetired: got %b expected %b", name, instr_retired, er);
        end
`ifdef CU_INSTR_COUNT_EN
        n_tests++;
        if (instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL %s InstrCount: got %0d expected %0d", name, instr_count, exp_count);
        end
`endif
        if (er) exp_count = exp_count + 1'b1;
    endtask

    task automatic step(input string name, input logic [6:0] op, input logic mr,
                        input logic [3:0] es, input logic ei, input logic eto,
                        input logic er);
        opcode    = op;
        mem_ready = mr;
        tick();
        check_out(name, es, ei, eto, er);
    endtask

    initial begin
        // R-type, BRANCH, STORE (opcode changed after decode), illegal,
        // JAL, fetch timeout, JAL.
        vecs[0]  = '{OP_X,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_R,     1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_X,     1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_X,     1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{OP_X,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_BR,    1'b0, 4'd8, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{OP_X,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_STORE, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_BAD,   1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_X,     1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{OP_X,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_BAD,   1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_X,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{OP_JAL,   1'b0, 4'd9, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{OP_X,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{OP_JAL,   1'b0, 4'd9, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{OP_X,     1'b0, 4'd0, 1'b0, 1'b0, 1'b1};

        reset_n   = 1'b0;
        opcode    = OP_X;
        mem_ready = 1'b0;
        #12;
        check_out("reset_init", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset in EXEC_R, checked before the next clock edge.
        step("rst_fetch", OP_X, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step("rst_decode", OP_R, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n   = 1'b0;
        exp_count = '0;
        #1;
        check_out("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("rst_held", 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        step("rst_release", OP_X, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].mr, vecs[i].st,
                 vecs[i].ill, vecs[i].to, vecs[i].ret);
        end

        // LOAD with three wait cycles; MemReady on the threshold cycle wins.
        step("ld_fetch", OP_LOAD, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step("ld_decode", OP_LOAD, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        step("ld_memaddr", OP_STORE, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        step("ld_wait1", OP_STORE, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        step("ld_wait2", OP_STORE, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        step("ld_wait3", OP_STORE, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        step("ld_ready", OP_STORE, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        step("ld_wb", OP_X, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // STORE that never sees MemReady: four cycles in MEMWRITE, then abort.
        step("st_to_fetch", OP_STORE, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step("st_to_decode", OP_STORE, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        step("st_to_addr", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_to_w1", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_to_w2", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_to_w3", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_to_abort", OP_X, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step("st_to_after", OP_STORE, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);

        // Same STORE, but MemReady arrives on the fourth cycle in MEMWRITE.
        step("st_ok_decode", OP_STORE, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        step("st_ok_addr", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_ok_w1", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_ok_w2", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_ok_w3", OP_X, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("st_ok_done", OP_X, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        step("st_ok_after", OP_X, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Counter wrap: 17 JAL instructions from a fresh reset.
        #2;
        reset_n   = 1'b0;
        exp_count = '0;
        #1;
        check_out("wrap_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step($sformatf("jal%0d_fetch", k), OP_JAL, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
            step($sformatf("jal%0d_decode", k), OP_JAL, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
            step($sformatf("jal%0d_jump", k), OP_X, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        step("wrap_final", OP_X, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
`ifdef CU_INSTR_COUNT_EN
        n_tests++;
        if (instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d expected 1", instr_count);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
